// File: rtl/ex_stage_pkg.sv
// Shared EX-stage types: ALU opcode encoding and operand-stage occupancy states.
// The ALU wrapper bench uses the same definitions.
package ex_stage_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_NOP  = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10
   } alu_op_t;

   // Occupancy of the main + skid register pair.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_t;

endpackage

// File: rtl/ex_fwd_mux.sv
// Per-operand bypass select: MEM result beats WB result beats register-file data.
// Register 0 is hardwired, so it never takes a forwarded value.
module ex_fwd_mux
   import ex_stage_pkg::*;
#(
   parameter int NBIT    = 32,
   parameter int RADDR_W = 5
) (
   input  logic [RADDR_W-1:0] src_addr,
   input  logic [NBIT-1:0]    rf_data,
   input  logic               mem_valid,
   input  logic [RADDR_W-1:0] mem_addr,
   input  logic [NBIT-1:0]    mem_data,
   input  logic               wb_valid,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [NBIT-1:0]    wb_data,
   output logic [NBIT-1:0]    data
);

   logic src_nz;
   logic mem_hit;
   logic wb_hit;

   assign src_nz  = |src_addr;
   assign mem_hit = src_nz && mem_valid && (mem_addr == src_addr);
   assign wb_hit  = src_nz && wb_valid  && (wb_addr  == src_addr);

   always_comb begin
      data = rf_data;
      if (mem_hit)     data = mem_data;
      else if (wb_hit) data = wb_data;
   end

endmodule

// File: rtl/ex_operand_stage.sv
// EX operand capture: resolves forwarding at acceptance and holds ALU operands in a
// main register backed by one skid register, so in_ready never depends on out_ready.
module ex_operand_stage
   import ex_stage_pkg::*;
#(
   parameter int NBIT    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  alu_op_t            in_func,
   input  logic [RADDR_W-1:0] in_rs1_addr,
   input  logic [RADDR_W-1:0] in_rs2_addr,
   input  logic [NBIT-1:0]    in_rs1_data,
   input  logic [NBIT-1:0]    in_rs2_data,
   input  logic [NBIT-1:0]    in_imm,
   input  logic               in_use_imm,
   input  logic               fwd_mem_valid,
   input  logic [RADDR_W-1:0] fwd_mem_addr,
   input  logic [NBIT-1:0]    fwd_mem_data,
   input  logic               fwd_wb_valid,
   input  logic [RADDR_W-1:0] fwd_wb_addr,
   input  logic [NBIT-1:0]    fwd_wb_data,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output alu_op_t            alu_func,
   output logic [NBIT-1:0]    alu_data1,
   output logic [NBIT-1:0]    alu_data2
);

   localparam int NUM_SRC = 2;

   typedef struct packed {
      alu_op_t         func;
      logic [NBIT-1:0] data1;
      logic [NBIT-1:0] data2;
   } operand_t;

   logic [NUM_SRC-1:0][RADDR_W-1:0] src_addr;
   logic [NUM_SRC-1:0][NBIT-1:0]    src_rf;
   logic [NUM_SRC-1:0][NBIT-1:0]    src_fwd;

   operand_t     in_op;
   operand_t     main_q;
   operand_t     skid_q;
   stage_state_t state_q;
   stage_state_t state_nx;

   logic acc;
   logic drn;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid;

   assign src_addr = {in_rs2_addr, in_rs1_addr};
   assign src_rf   = {in_rs2_data, in_rs1_data};

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_fwd
         ex_fwd_mux #(
            .NBIT    (NBIT),
            .RADDR_W (RADDR_W)
         ) u_fwd (
            .src_addr  (src_addr[g]),
            .rf_data   (src_rf[g]),
            .mem_valid (fwd_mem_valid),
            .mem_addr  (fwd_mem_addr),
            .mem_data  (fwd_mem_data),
            .wb_valid  (fwd_wb_valid),
            .wb_addr   (fwd_wb_addr),
            .wb_data   (fwd_wb_data),
            .data      (src_fwd[g])
         );
      end
   endgenerate

   // Immediate overrides RS2 outright, forwarded or not.
   assign in_op.func  = in_func;
   assign in_op.data1 = src_fwd[0];
   assign in_op.data2 = in_use_imm ? in_imm : src_fwd[1];

   assign acc = in_valid  & in_ready;
   assign drn = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_nx;
         in_ready  <= (state_nx != ST_FULL);
         out_valid <= (state_nx != ST_EMPTY);
      end
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         ST_EMPTY: if (acc) state_nx = ST_ONE;
         ST_ONE: begin
            if (acc && !drn)      state_nx = ST_FULL;
            else if (!acc && drn) state_nx = ST_EMPTY;
         end
         ST_FULL:  if (drn) state_nx = ST_ONE;
         default:  state_nx = ST_EMPTY;
      endcase
      if (flush) state_nx = ST_EMPTY;
   end

   // A flush suppresses every load; a drain in that cycle still retires the entry.
   always_comb begin
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (!flush) begin
         case (state_q)
            ST_EMPTY: load_main_in = acc;
            ST_ONE: begin
               load_main_in = acc & drn;
               load_skid    = acc & ~drn;
            end
            ST_FULL:  load_main_skid = drn;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '{func: ALU_NOP, data1: '0, data2: '0};
         skid_q <= '{func: ALU_NOP, data1: '0, data2: '0};
      end else begin
         if (load_main_in)        main_q <= in_op;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_op;
      end
   end

   assign alu_func  = main_q.func;
   assign alu_data1 = main_q.data1;
   assign alu_data2 = main_q.data2;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: driver pushes expected operands on acceptance,
// a negedge monitor pops and compares on every output transfer.
module tb_ex_operand_stage;
   import ex_stage_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   alu_op_t       in_func;
   logic [4:0]    in_rs1_addr, in_rs2_addr;
   logic [31:0]   in_rs1_data, in_rs2_data, in_imm;
   logic          in_use_imm;
   logic          fwd_mem_valid, fwd_wb_valid;
   logic [4:0]    fwd_mem_addr, fwd_wb_addr;
   logic [31:0]   fwd_mem_data, fwd_wb_data;
   logic          flush, out_valid, out_ready;
   alu_op_t       alu_func;
   logic [31:0]   alu_data1, alu_data2;

   typedef struct {
      logic [3:0]  f;
      logic [31:0] d1;
      logic [31:0] d2;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ex_operand_stage #(.NBIT(32), .RADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm),
      .fwd_mem_valid(fwd_mem_valid), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_func(alu_func), .alu_data1(alu_data1), .alu_data2(alu_data2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every output transfer must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL out_unexpected: got %0h/%0h/%0h want none", alu_func, alu_data1, alu_data2);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (alu_func !== e.f || alu_data1 !== e.d1 || alu_data2 !== e.d2) begin
               bad++;
               $display("FAIL out_data: got %0h/%0h/%0h want %0h/%0h/%0h",
                        alu_func, alu_data1, alu_data2, e.f, e.d1, e.d2);
            end
         end
      end
   end

   task automatic fwd(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic wv, input logic [4:0] wa, input logic [31:0] wd);
      fwd_mem_valid = mv; fwd_mem_addr = ma; fwd_mem_data = md;
      fwd_wb_valid  = wv; fwd_wb_addr  = wa; fwd_wb_data  = wd;
   endtask

   task automatic setin(input alu_op_t f, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic ui);
      in_func = f; in_rs1_addr = a1; in_rs2_addr = a2;
      in_rs1_data = r1; in_rs2_data = r2; in_imm = imm; in_use_imm = ui;
      in_valid = 1'b1;
   endtask

   // Holds in_valid until accepted (bounded), pushing the expectation at acceptance.
   task automatic send(input string name, input alu_op_t f, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic ui,
                       input logic [31:0] e1, input logic [31:0] e2, output int waits);
      logic acc;
      setin(f, a1, a2, r1, r2, imm, ui);
      acc = 1'b0;
      waits = 0;
      while (!acc && waits < 50) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) q.push_back('{f: f, d1: e1, d2: e2});
         @(posedge clk); #1;
         waits++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         total++; bad++;
         $display("FAIL %s_timeout: got no accept want accept", name);
      end else begin
         chk({name, "_out_valid"}, 64'(out_valid), 64'd1);
      end
   endtask

   initial begin
      int w;
      rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      setin(ALU_NOP, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      in_valid = 1'b0;
      fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_func",      64'(alu_func),  64'(ALU_NOP));
      chk("rst_data1",     64'(alu_data1), 64'd0);
      chk("rst_data2",     64'(alu_data2), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Streaming with out_ready high: forwarding cases.
      out_ready = 1'b1;
      fwd(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd3, 32'h00005555);
      send("prio", ALU_ADD, 5'd3, 5'd4, 32'h11111111, 32'h22222222, 32'h0, 1'b0,
           32'hAAAA0000, 32'h22222222, w);
      fwd(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
      send("r0", ALU_OR, 5'd0, 5'd5, 32'h0, 32'h33, 32'h0, 1'b0, 32'h0, 32'h33, w);
      fwd(1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 5'd6, 32'h0000600D);
      send("imm", ALU_SUB, 5'd6, 5'd7, 32'h10, 32'h44, 32'hFFFFFFF0, 1'b1,
           32'h0000600D, 32'hFFFFFFF0, w);
      fwd(1'b1, 5'd10, 32'h0BADBAD0, 1'b1, 5'd9, 32'hCAFEF00D);
      send("wb", ALU_XOR, 5'd8, 5'd9, 32'h1, 32'h2, 32'h0, 1'b0, 32'h1, 32'hCAFEF00D, w);
      fwd(1'b0, 5'd2, 32'h00000BAD, 1'b0, 5'd2, 32'h00000BAD);
      send("novld", ALU_SLT, 5'd2, 5'd2, 32'h12345678, 32'h12345678, 32'h0, 1'b0,
           32'h12345678, 32'h12345678, w);
      fwd(1'b1, 5'd1, 32'h00000F0F, 1'b1, 5'd1, 32'h0000F0F0);
      send("both", ALU_AND, 5'd1, 5'd1, 32'h7, 32'h8, 32'h0, 1'b0, 32'h00000F0F, 32'h00000F0F, w);
      fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (3) @(posedge clk); #1;
      chk("stream_drained", 64'(q.size()), 64'd0);

      // Backpressure: two fill main+skid, third waits until drain starts.
      out_ready = 1'b0;
      send("bpA", ALU_ADD, 5'd11, 5'd12, 32'hA1, 32'hA2, 32'h0, 1'b0, 32'hA1, 32'hA2, w);
      chk("bpA_in_ready", 64'(in_ready), 64'd1);
      send("bpB", ALU_SUB, 5'd13, 5'd14, 32'hB1, 32'hB2, 32'h0, 1'b0, 32'hB1, 32'hB2, w);
      chk("bpB_in_ready", 64'(in_ready), 64'd0);
      setin(ALU_SLL, 5'd15, 5'd16, 32'hC1, 32'hC2, 32'h0, 1'b0);
      repeat (2) @(posedge clk); #1;
      chk("bp_full_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_data1", 64'(alu_data1), 64'hA1);
      chk("bp_hold_func",  64'(alu_func),  64'(ALU_ADD));
      out_ready = 1'b1;
      send("bpC", ALU_SLL, 5'd15, 5'd16, 32'hC1, 32'hC2, 32'h0, 1'b0, 32'hC1, 32'hC2, w);
      repeat (4) @(posedge clk); #1;
      chk("bp_drained", 64'(q.size()), 64'd0);
      chk("bp_idle_valid", 64'(out_valid), 64'd0);

      // Flush while FULL with a new instruction offered.
      out_ready = 1'b0;
      send("flA", ALU_ADD, 5'd17, 5'd18, 32'hD1, 32'hD2, 32'h0, 1'b0, 32'hD1, 32'hD2, w);
      send("flB", ALU_OR,  5'd19, 5'd20, 32'hE1, 32'hE2, 32'h0, 1'b0, 32'hE1, 32'hE2, w);
      setin(ALU_XOR, 5'd21, 5'd22, 32'hF1, 32'hF2, 32'h0, 1'b0);
      flush = 1'b1;
      q.delete();
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready",  64'(in_ready),  64'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("flush_stays_empty", 64'(out_valid), 64'd0);

      // Reset while FULL, then first accept right after release.
      out_ready = 1'b0;
      send("rsA", ALU_ADD, 5'd23, 5'd24, 32'h101, 32'h102, 32'h0, 1'b0, 32'h101, 32'h102, w);
      send("rsB", ALU_SUB, 5'd25, 5'd26, 32'h201, 32'h202, 32'h0, 1'b0, 32'h201, 32'h202, w);
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      chk("mrst_in_ready",  64'(in_ready),  64'd1);
      chk("mrst_func",      64'(alu_func),  64'(ALU_NOP));
      chk("mrst_data1",     64'(alu_data1), 64'd0);
      chk("mrst_data2",     64'(alu_data2), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send("post", ALU_SRA, 5'd27, 5'd0, 32'h301, 32'h302, 32'h0, 1'b0, 32'h301, 32'h302, w);
      chk("post_first_edge", 64'(w), 64'd1);
      repeat (3) @(posedge clk); #1;
      chk("final_drained", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
